xrom_streamer: RTL and testbench

Read-side sequencer for the xrom block. It accepts a start command with a base address and word count, drives the ROM's `addr`/`nd` port, and absorbs the ROM's one-cycle read latency in a 2-entry output buffer. It presents the words on a valid/ready stream with a last-word marker. It sits between an xrom instance and any downstream consumer, such as a DAC feeder or coefficient loader, that can apply backpressure.

---
 rtl/xrom_streamer.sv | 190 +++++++++++++++++++
 tb/tb_xrom_streamer.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xrom_streamer.sv
// xrom_streamer: read-side sequencer for an xrom instance.
// Accepts a start command (base address + word count), drives the ROM
// addr/nd port, and absorbs the ROM's one-cycle read latency in a 2-entry
// output buffer. Words leave on a valid/ready stream with a last marker.
// Optional build macro: XSTREAM_LOOP_EN enables continuous looping over the
// programmed window, ended by the stop input. Undefined: one-shot transfers.
module xrom_streamer #(
  parameter int BWID      = 32,
  parameter int BWID_ADDR = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BWID_ADDR-1:0] start_addr,
  input  logic [BWID_ADDR:0]   length,
  input  logic                 stop,
  output logic [BWID_ADDR-1:0] rom_addr,
  output logic                 rom_nd,
  input  logic [BWID-1:0]      rom_dout,
  output logic [BWID-1:0]      m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  localparam logic [BWID_ADDR-1:0] ADDR_ONE = BWID_ADDR'(1);
  localparam logic [BWID_ADDR:0]   LEN_ONE  = (BWID_ADDR+1)'(1);

  state_t               state;
  logic [BWID_ADDR-1:0] cur_addr;
  logic [BWID_ADDR:0]   remaining;
  logic                 inflight;
  logic                 inflight_last;

  // Two-entry output buffer, indexed by single-bit pointers.
  logic [BWID-1:0]      fifo_data [2];
  logic                 fifo_last [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           cnt;

  logic                 pop;
  logic                 issue;
  logic                 last_issue;
  logic                 drain_done;
  logic [2:0]           occ_next;

`ifdef XSTREAM_LOOP_EN
  logic [BWID_ADDR-1:0] base_addr;
  logic [BWID_ADDR:0]   base_len;
`else
  logic                 unused_stop;
  assign unused_stop = stop;
`endif

  assign m_valid  = (cnt != 2'd0);
  assign m_data   = fifo_data[rd_ptr];
  assign m_last   = m_valid && fifo_last[rd_ptr];
  assign rom_addr = cur_addr;
  assign rom_nd   = issue;

  // Issue decision: buffer occupancy after this edge, counting the word in
  // flight from the ROM, must leave room for the read issued now.
  // NOTE: every signal here is assigned on every pass, so no latch can form.
  always_comb begin
    pop        = m_valid && m_ready;
    occ_next   = {1'b0, cnt} - {2'b00, pop} + {2'b00, inflight};
    issue      = (state == S_RUN) && (remaining != '0) && (occ_next < 3'd2);
    last_issue = issue && (remaining == LEN_ONE);
    drain_done = (state == S_DRAIN) && !inflight && (occ_next == 3'd0);
  end

  // Control FSM: command acceptance, address/count sequencing, completion.
  // NOTE: registers use <= so every update in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef XSTREAM_LOOP_EN
      base_addr     <= '0;
      base_len      <= '0;
`endif
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        inflight_last <= last_issue;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr  <= start_addr;
            remaining <= length;
`ifdef XSTREAM_LOOP_EN
            base_addr <= start_addr;
            base_len  <= length;
`endif
            if (length == '0) begin
              // Empty command completes immediately without touching the ROM.
              done <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (issue) begin
            if (last_issue) begin
`ifdef XSTREAM_LOOP_EN
              // End of a pass: rewind to the window start without a gap.
              cur_addr  <= base_addr;
              remaining <= base_len;
`else
              cur_addr  <= cur_addr + ADDR_ONE;
              remaining <= '0;
              state     <= S_DRAIN;
`endif
            end else begin
              cur_addr  <= cur_addr + ADDR_ONE;
              remaining <= remaining - LEN_ONE;
            end
          end
`ifdef XSTREAM_LOOP_EN
          // Leaving RUN makes stop sticky: DRAIN never issues again.
          if (stop) begin
            state <= S_DRAIN;
          end
`endif
        end

        S_DRAIN: begin
          if (drain_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output buffer: capture ROM data the cycle after a read, release on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two entries are cleared so m_data reads 0 out of reset.
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      cnt          <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= rom_dout;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({inflight, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_xrom_streamer.sv
// Self-checking bench for xrom_streamer: a ROM model with ROM[k]=k, a stream
// scoreboard fed at command time and drained on every handshake, and one
// task per scenario. Loop-mode scenarios build only with XSTREAM_LOOP_EN.
module tb_xrom_streamer;

  localparam int BWID = 32;
  localparam int AW   = 10;
  localparam int AWW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance
  logic            start = 1'b0;
  logic [AW-1:0]   start_addr = '0;
  logic [AW:0]     length = '0;
  logic            stop = 1'b0;
  logic [AW-1:0]   rom_addr;
  logic            rom_nd;
  logic [BWID-1:0] rom_dout = '0;
  logic [BWID-1:0] m_data;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic            m_last;
  logic            busy;
  logic            done;

  // Narrow-address instance for the wrap-around case
  logic            start_w = 1'b0;
  logic [AWW-1:0]  start_addr_w = '0;
  logic [AWW:0]    length_w = '0;
  logic [AWW-1:0]  rom_addr_w;
  logic            rom_nd_w;
  logic [BWID-1:0] rom_dout_w = '0;
  logic [BWID-1:0] m_data_w;
  logic            m_valid_w;
  logic            m_last_w;
  logic            busy_w;
  logic            done_w;

  xrom_streamer #(.BWID(BWID), .BWID_ADDR(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .length(length), .stop(stop), .rom_addr(rom_addr), .rom_nd(rom_nd),
    .rom_dout(rom_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  xrom_streamer #(.BWID(BWID), .BWID_ADDR(AWW)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .start_addr(start_addr_w),
    .length(length_w), .stop(1'b0), .rom_addr(rom_addr_w), .rom_nd(rom_nd_w),
    .rom_dout(rom_dout_w), .m_data(m_data_w), .m_valid(m_valid_w),
    .m_ready(1'b1), .m_last(m_last_w), .busy(busy_w), .done(done_w)
  );

  // ROM models: registered read on nd, output held otherwise, ROM[k]=k.
  always @(posedge clk) if (rom_nd) rom_dout <= BWID'(rom_addr);
  always @(posedge clk) if (rom_nd_w) rom_dout_w <= BWID'(rom_addr_w);

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [BWID-1:0] data;
    logic            last;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int              words_seen = 0;
  int              issued = 0;
  int              popped = 0;
  logic            hold_prev = 1'b0;
  logic [BWID-1:0] prev_data = '0;
  logic            prev_last = 1'b0;

  // Stream monitor: scoreboard compare on handshake, hold stability under
  // backpressure, and the outstanding-read bound.
  always @(negedge clk) begin
    if (rst) begin
      issued    = 0;
      popped    = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b data=%0d last=%0b, required valid=1 data=%0d last=%0b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        checks++;
        words_seen++;
        popped++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_word: got data=%0d last=%0b, required no word", m_data, m_last);
        end else begin
          mon_e = exp_q.pop_front();
          if (m_data !== mon_e.data || m_last !== mon_e.last) begin
            errors++;
            $display("FAIL stream_word: got data=%0d last=%0b, required data=%0d last=%0b",
                     m_data, m_last, mon_e.data, mon_e.last);
          end
        end
      end
      if (rom_nd === 1'b1) begin
        issued++;
        checks++;
        if (issued - popped > 2) begin
          errors++;
          $display("FAIL outstanding: %0d reads beyond consumer, required at most 2", issued - popped);
        end
      end
      hold_prev = (m_valid === 1'b1) && (m_ready !== 1'b1);
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic push_exp(input int addr, input int len);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.data = BWID'((addr + k) % (1 << AW));
      e.last = (k == len - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({rom_nd, rom_addr, m_valid, m_last, m_data, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_main: nd=%0b addr=%0d valid=%0b last=%0b data=%0d busy=%0b done=%0b, required all 0",
               rom_nd, rom_addr, m_valid, m_last, m_data, busy, done);
    end
    checks++;
    if ({rom_nd_w, rom_addr_w, m_valid_w, m_last_w, m_data_w, busy_w, done_w} !== '0) begin
      errors++;
      $display("FAIL reset_wrap: nd=%0b addr=%0d valid=%0b data=%0d busy=%0b done=%0b, required all 0",
               rom_nd_w, rom_addr_w, m_valid_w, m_data_w, busy_w, done_w);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int   first_valid = -1;
    int   done_cyc = -1;
    int   done_cnt = 0;
    logic busy1 = 1'b0;
    logic nd1 = 1'b0;
    push_exp(4, 5);
    m_ready = 1'b1; start_addr = 10'd4; length = 11'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin busy1 = busy; nd1 = rom_nd; end
      if (m_valid === 1'b1 && first_valid < 0) first_valid = c;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy1 !== 1'b1 || nd1 !== 1'b1) begin
      errors++;
      $display("FAIL basic_issue: busy=%0b nd=%0b one cycle after start, required 1 1", busy1, nd1);
    end
    checks++;
    if (first_valid != 3) begin
      errors++;
      $display("FAIL basic_latency: first valid at cycle %0d, required 3", first_valid);
    end
    checks++;
    if (done_cyc != 8 || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done: done at cycle %0d count %0d, required cycle 8 count 1", done_cyc, done_cnt);
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end: %0d words missing busy=%0b, required 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_wrap();
    int got_a[4];
    int got_d[4];
    int na = 0;
    int nw = 0;
    start_addr_w = 4'd14; length_w = 5'd4; start_w = 1'b1;
    @(posedge clk);
    #1 start_w = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (rom_nd_w === 1'b1 && na < 4) begin got_a[na] = int'(rom_addr_w); na++; end
      if (m_valid_w === 1'b1 && nw < 4) begin got_d[nw] = int'(m_data_w); nw++; end
      @(posedge clk);
      #1;
    end
    checks++;
    if (na != 4 || nw != 4) begin
      errors++;
      $display("FAIL wrap_count: %0d reads %0d words, required 4 4", na, nw);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k < na && k < nw && (got_a[k] != (14 + k) % 16 || got_d[k] != (14 + k) % 16)) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: addr=%0d data=%0d, required %0d", k, got_a[k], got_d[k], (14 + k) % 16);
      end
    end
  endtask

  // mode 0: always ready; 1: ready low for 5 cycles; 2: ready toggling
  task automatic run_transfer(input string name, input int addr, input int len, input int mode);
    int done_cnt = 0;
    push_exp(addr, len);
    m_ready = 1'b1; start_addr = AW'(addr); length = (AW+1)'(len); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      case (mode)
        1:       m_ready = !(c >= 4 && c < 9);
        2:       m_ready = c[0];
        default: m_ready = 1'b1;
      endcase
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: done pulses=%0d missing=%0d busy=%0b, required 1 0 0", name, done_cnt, exp_q.size(), busy);
    end
  endtask

  task automatic test_backpressure();
    run_transfer("bp_hold", 20, 10, 1);
    run_transfer("bp_toggle", 50, 6, 2);
  endtask

  task automatic test_len0();
    logic done1 = 1'b0;
    logic busy1 = 1'b1;
    logic done2 = 1'b1;
    logic nd_seen = 1'b0;
    start_addr = 10'd7; length = '0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin done1 = done; busy1 = busy; end
      if (c == 2) done2 = done;
      if (rom_nd !== 1'b0) nd_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL len0_done: done=%0b busy=%0b after start, required 1 0", done1, busy1);
    end
    checks++;
    if (done2 !== 1'b0 || nd_seen !== 1'b0) begin
      errors++;
      $display("FAIL len0_quiet: done2=%0b nd_seen=%0b, required 0 0", done2, nd_seen);
    end
  endtask

  task automatic test_busy_start();
    int   done_cnt = 0;
    logic busy1 = 1'b0;
    push_exp(0, 3);
    start_addr = '0; length = 11'd3; start = 1'b1;
    @(posedge clk);
    #1 start_addr = 10'd100; length = 11'd5;
    for (int c = 1; c <= 15; c++) begin
      if (c == 3) start = 1'b0;
      @(negedge clk);
      if (c == 1) busy1 = busy;
      if (done === 1'b1) done_cnt++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_busy: busy=%0b, required 1", busy1);
    end
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: done=%0d missing=%0d busy=%0b valid=%0b, required 1 0 0 0",
               done_cnt, exp_q.size(), busy, m_valid);
    end
  endtask

  task automatic test_start_on_done();
    int   done_cnt = 0;
    logic found = 1'b0;
    push_exp(10, 2);
    start_addr = 10'd10; length = 11'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        found = 1'b1;
        push_exp(30, 2);
        start_addr = 10'd30; length = 11'd2; start = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (found !== 1'b1) begin
      errors++;
      $display("FAIL sod_first_done: done=%0b within 20 cycles, required 1", found);
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL sod_accept: busy=%0b done=%0b, required 1 0", busy, done);
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL sod_second: done pulses=%0d missing=%0d, required 1 0", done_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int   ws0 = words_seen;
    logic reached = 1'b0;
    push_exp(40, 8);
    start_addr = 10'd40; length = 11'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (words_seen >= ws0 + 2) begin reached = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    checks++;
    if (reached !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_words: %0d words, required 2", words_seen - ws0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    exp_q.delete();
    checks++;
    if ({rom_nd, rom_addr, m_valid, m_last, m_data, busy, done} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: nd=%0b addr=%0d valid=%0b last=%0b data=%0d busy=%0b done=%0b, required all 0",
               rom_nd, rom_addr, m_valid, m_last, m_data, busy, done);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    test_basic();
  endtask

`ifdef XSTREAM_LOOP_EN
  task automatic test_loop();
    int   ws0;
    int   done_cnt = 0;
    for (int p = 0; p < 12; p++) push_exp(0, 3);
    start_addr = '0; length = 11'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    ws0 = words_seen;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop_done: done pulses=%0d busy=%0b, required 1 0", done_cnt, busy);
    end
    checks++;
    if (words_seen - ws0 < 1 || words_seen - ws0 > 2) begin
      errors++;
      $display("FAIL loop_drain: %0d words after stop, required 1..2", words_seen - ws0);
    end
    checks++;
    if (ws0 < 17) begin
      errors++;
      $display("FAIL loop_continuous: %0d words before stop, required at least 17", ws0);
    end
    exp_q.delete();
  endtask
`endif

  initial begin
    test_reset();
`ifdef XSTREAM_LOOP_EN
    test_len0();
    test_loop();
`else
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_busy_start();
    test_start_on_done();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
